// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a uart transmitter: one launch pulse per frame, data held
// stable for the whole frame, optional idle gap and a sticky busy-timeout flag.
module uart_tx_feeder #(
    parameter int G_WORD_WIDTH   = 8,
    parameter int G_DEPTH        = 16,
    parameter int G_GAP_CYCLES   = 0,
    parameter int G_BUSY_TIMEOUT = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_s_valid,
    input  logic [G_WORD_WIDTH-1:0]   i_s_data,
    output logic                      o_s_ready,
    input  logic                      i_flush,
    output logic                      o_tx_en,
    output logic [G_WORD_WIDTH-1:0]   o_tx_data,
    input  logic                      i_tx_busy,
    output logic [$clog2(G_DEPTH):0]  o_fifo_count,
    output logic                      o_fifo_empty,
    output logic                      o_fifo_full,
    output logic                      o_idle,
    output logic                      o_err
);

    localparam int C_AW   = $clog2(G_DEPTH);
    localparam int C_TMAX = (G_GAP_CYCLES > G_BUSY_TIMEOUT) ? G_GAP_CYCLES : G_BUSY_TIMEOUT;
    localparam int C_TW   = (C_TMAX > 1) ? $clog2(C_TMAX) : 1;
    localparam logic [C_TW-1:0] C_BUSY_LOAD = C_TW'(G_BUSY_TIMEOUT - 1);
    localparam logic [C_TW-1:0] C_GAP_LOAD  = C_TW'((G_GAP_CYCLES > 0) ? G_GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t                  r_state;
    logic [G_WORD_WIDTH-1:0] r_mem [G_DEPTH];
    logic [C_AW-1:0]         r_wr_ptr;
    logic [C_AW-1:0]         r_rd_ptr;
    logic [C_AW:0]           r_count;
    logic [C_TW-1:0]         r_timer;
    logic                    r_tx_en;
    logic [G_WORD_WIDTH-1:0] r_tx_data;
    logic                    r_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == (C_AW+1)'(G_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_s_valid && o_s_ready && !i_flush;
    // Pop decision is shared by the FIFO pointers and the FSM so both agree.
    assign w_pop   = (r_state == S_IDLE) && !w_empty && !i_tx_busy;

    assign o_s_ready    = !w_full && !i_rst;
    assign o_fifo_count = r_count;
    assign o_fifo_empty = w_empty;
    assign o_fifo_full  = w_full;
    assign o_idle       = (r_state == S_IDLE) && w_empty;
    assign o_tx_en      = r_tx_en;
    assign o_tx_data    = r_tx_data;
    assign o_err        = r_err;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_s_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_tx_en   <= 1'b0;
            r_tx_data <= '0;
            r_err     <= 1'b0;
            r_timer   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx_en <= 1'b0;
                    if (w_pop) begin
                        r_tx_data <= r_mem[r_rd_ptr];
                        r_tx_en   <= 1'b1;
                        r_state   <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_tx_en <= 1'b0;
                    r_timer <= C_BUSY_LOAD;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_timer == '0) begin
                        // Word is dropped; no retry, only the sticky flag.
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        if (G_GAP_CYCLES == 0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_timer <= C_GAP_LOAD;
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (r_timer == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_tx_en <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: queue-based reference model, behavioural uart busy
// model, FIFO vector table and directed multi-cycle sequences.
module tb_uart_tx_feeder;

    localparam int D     = 16;
    localparam int FRAME = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       v0, fl0, rdy0, en0, busy0, emp0, full0, idle0, err0;
    logic [7:0] d0, txd0;
    logic [4:0] cnt0;

    logic       v1, fl1, rdy1, en1, busy1, emp1, full1, idle1, err1;
    logic [7:0] d1, txd1;
    logic [4:0] cnt1;

    uart_tx_feeder #(.G_WORD_WIDTH(8), .G_DEPTH(D), .G_GAP_CYCLES(0), .G_BUSY_TIMEOUT(4)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_s_valid(v0), .i_s_data(d0), .o_s_ready(rdy0),
        .i_flush(fl0), .o_tx_en(en0), .o_tx_data(txd0), .i_tx_busy(busy0),
        .o_fifo_count(cnt0), .o_fifo_empty(emp0), .o_fifo_full(full0),
        .o_idle(idle0), .o_err(err0)
    );

    uart_tx_feeder #(.G_WORD_WIDTH(8), .G_DEPTH(D), .G_GAP_CYCLES(10), .G_BUSY_TIMEOUT(4)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_s_valid(v1), .i_s_data(d1), .o_s_ready(rdy1),
        .i_flush(fl1), .o_tx_en(en1), .o_tx_data(txd1), .i_tx_busy(busy1),
        .o_fifo_count(cnt1), .o_fifo_empty(emp1), .o_fifo_full(full1),
        .o_idle(idle1), .o_err(err1)
    );

    // Behavioural uart: a launch seen while free starts a FRAME-cycle busy period.
    int         ucnt;
    logic       attached;
    logic [7:0] rx_q[$];
    always @(posedge clk) begin
        if (rst) ucnt <= 0;
        else if (ucnt != 0) ucnt <= ucnt - 1;
        else if (en0 && attached) begin
            ucnt <= FRAME;
            rx_q.push_back(txd0);
        end
    end
    assign busy0 = attached && (ucnt != 0);

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    int         en_pulses = 0;
    logic       prev_en = 1'b0;
    logic [7:0] last_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: capture inputs at the edge, update the reference queue, check dut0.
    task automatic step();
        logic       pv, pfl, prst;
        logic [7:0] pd, w;
        int         sz0;
        @(posedge clk);
        pv = v0; pd = d0; pfl = fl0; prst = rst;
        @(negedge clk);
        sz0 = exp_q.size();
        if (prst) begin
            exp_q.delete();
        end else begin
            if (en0) begin
                check("pop_nonempty", 32'(sz0 != 0), 1);
                if (sz0 != 0) begin
                    w = exp_q.pop_front();
                    check("launch_data", txd0, w);
                end
            end
            if (pfl) exp_q.delete();
            else if (pv && sz0 < D) exp_q.push_back(pd);
        end
        if (en0) begin
            en_pulses++;
            check("no_launch_while_busy", busy0, 0);
            check("single_pulse", prev_en, 0);
        end else if (!prst) begin
            check("data_hold", txd0, last_data);
        end
        check("fifo_count", cnt0, exp_q.size());
        check("fifo_empty", emp0, 32'(exp_q.size() == 0));
        check("fifo_full", full0, 32'(exp_q.size() == D));
        check("s_ready", rdy0, 32'(exp_q.size() < D && !rst));
        prev_en = en0;
        last_data = txd0;
        #2;
    endtask

    task automatic push_word(input logic [7:0] b);
        int   n;
        logic acc;
        v0 = 1'b1; d0 = b; n = 0; acc = 1'b0;
        while (!acc && n < 500) begin
            acc = rdy0;
            step();
            n++;
        end
        check("push_accepted", acc, 1);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (!(idle0 && !busy0) && n < budget) begin
            step();
            n++;
        end
        check("drain_done", 32'(idle0 && !busy0), 1);
    endtask

    task automatic wait_busy0(input logic lvl);
        int n;
        n = 0;
        while (busy0 !== lvl && n < 200) begin
            step();
            n++;
        end
        check("wait_busy_level", busy0, lvl);
    endtask

    task automatic chk_reset0(input string tag);
        check({tag, "_tx_en"}, en0, 0);
        check({tag, "_tx_data"}, txd0, 0);
        check({tag, "_count"}, cnt0, 0);
        check({tag, "_empty"}, emp0, 1);
        check({tag, "_full"}, full0, 0);
        check({tag, "_err"}, err0, 0);
        check({tag, "_idle"}, idle0, 1);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       fl;
        int         cnt;
        logic       rdy;
        logic       full;
        logic       emp;
    } vec_t;
    vec_t tbl[22];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb, base, n;
        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, 8'(8'hC0 + i), 1'b0, i + 1, (i + 1 < D), (i + 1 == D), 1'b0};
        tbl[16] = '{1'b1, 8'hEE, 1'b0, 16, 1'b0, 1'b1, 1'b0};  // full: offer refused
        tbl[17] = '{1'b0, 8'h00, 1'b1, 0,  1'b1, 1'b0, 1'b1};  // flush
        tbl[18] = '{1'b1, 8'hD7, 1'b0, 1,  1'b1, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 8'hEF, 1'b1, 0,  1'b1, 1'b0, 1'b1};  // flush drops same-cycle push
        tbl[20] = '{1'b1, 8'hD0, 1'b0, 1,  1'b1, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 8'h00, 1'b0, 1,  1'b1, 1'b0, 1'b0};

        rst = 1'b1; v0 = 1'b0; d0 = 8'h00; fl0 = 1'b0; attached = 1'b1;
        v1 = 1'b0; d1 = 8'h00; fl1 = 1'b0; busy1 = 1'b1;
        step(); step();
        chk_reset0("rst0");
        check("rst0_ready", rdy0, 0);
        check("rst1_idle", idle1, 1);
        check("rst1_count", cnt1, 0);
        check("rst1_ready", rdy1, 0);
        rst = 1'b0;
        #1 check("ready_after_rst", rdy0, 1);
        step();

        // FIFO vectors on dut1 with busy held high so nothing is popped
        for (int i = 0; i < 22; i++) begin
            v1 = tbl[i].v; d1 = tbl[i].d; fl1 = tbl[i].fl;
            step();
            check($sformatf("vec%0d_count", i), cnt1, tbl[i].cnt);
            check($sformatf("vec%0d_ready", i), rdy1, tbl[i].rdy);
            check($sformatf("vec%0d_full", i), full1, tbl[i].full);
            check($sformatf("vec%0d_empty", i), emp1, tbl[i].emp);
            check($sformatf("vec%0d_no_launch", i), en1, 0);
        end
        v1 = 1'b0; fl1 = 1'b0;

        // Gap: next launch exactly 11 edges after busy is first seen low
        busy1 = 1'b0;
        step();
        check("gap_launch1_en", en1, 1);
        check("gap_launch1_data", txd1, 8'hD0);
        v1 = 1'b1; d1 = 8'hD1;
        step();
        v1 = 1'b0; busy1 = 1'b1;
        repeat (5) step();
        busy1 = 1'b0;
        step();
        n = 0;
        while (!en1 && n < 40) begin
            step();
            n++;
        end
        check("gap_cycles", n, 11);
        check("gap_launch2_data", txd1, 8'hD1);
        repeat (8) step();
        check("gap_idle_after_timeout", idle1, 1);

        // Single push latency
        rb = rx_q.size();
        v0 = 1'b1; d0 = 8'hA5;
        step();
        v0 = 1'b0;
        check("lat_k_en", en0, 0);
        step();
        check("lat_k1_en", en0, 1);
        check("lat_k1_data", txd0, 8'hA5);
        wait_drain(100);
        check("single_rx_n", rx_q.size() - rb, 1);
        if (rx_q.size() > rb) check("single_rx_data", rx_q[rb], 8'hA5);
        check("single_idle", idle0, 1);

        // Burst to full
        rb = rx_q.size(); base = en_pulses;
        for (int i = 0; i < 17; i++) push_word(8'(i));
        v0 = 1'b0;
        check("burst_full", full0, 1);
        check("burst_count", cnt0, 16);
        v0 = 1'b1; d0 = 8'h11;
        #1 check("burst_ready_full", rdy0, 0);
        step();
        v0 = 1'b0;
        check("burst_no_push_full", cnt0, 16);
        wait_drain(17 * (FRAME + 6) + 50);
        check("burst_pulses", en_pulses - base, 17);
        check("burst_rx_n", rx_q.size() - rb, 17);
        for (int i = 0; i < 17 && rb + i < rx_q.size(); i++)
            check($sformatf("burst_rx%0d", i), rx_q[rb + i], 8'(i));

        // Concurrent push and pop with 5 queued
        rb = rx_q.size();
        push_word(8'h50);
        v0 = 1'b0;
        wait_busy0(1'b1);
        for (int i = 1; i <= 5; i++) push_word(8'(8'h50 + i));
        v0 = 1'b0;
        check("cc_count_pre", cnt0, 5);
        n = 0;
        while (ucnt != 1 && n < 200) begin
            step();
            n++;
        end
        check("cc_frame_end", 32'(ucnt == 1), 1);
        step();
        step();
        v0 = 1'b1; d0 = 8'h56;
        step();
        v0 = 1'b0;
        check("cc_pop", en0, 1);
        check("cc_count", cnt0, 5);
        wait_drain(7 * (FRAME + 6) + 50);
        check("cc_rx_n", rx_q.size() - rb, 7);
        for (int i = 0; i < 7 && rb + i < rx_q.size(); i++)
            check($sformatf("cc_rx%0d", i), rx_q[rb + i], 8'(8'h50 + i));

        // 40 sequential bytes through the wrapping pointers
        rb = rx_q.size();
        for (int i = 0; i < 40; i++) push_word(8'(8'h80 + i));
        v0 = 1'b0;
        wait_drain(40 * (FRAME + 6) + 50);
        check("wrap_rx_n", rx_q.size() - rb, 40);
        for (int i = 0; i < 40 && rb + i < rx_q.size(); i++)
            check($sformatf("wrap_rx%0d", i), rx_q[rb + i], 8'(8'h80 + i));

        // Random traffic against the reference queue
        for (int i = 0; i < 400; i++) begin
            v0 = ($urandom_range(0, 2) != 0);
            d0 = 8'($urandom);
            step();
        end
        v0 = 1'b0;
        wait_drain(D * (FRAME + 6) + 100);
        check("rand_drained_model", exp_q.size(), 0);
        check("rand_drained_count", cnt0, 0);

        // Flush during frame 0x3C
        rb = rx_q.size(); base = en_pulses;
        push_word(8'h3C);
        v0 = 1'b0;
        wait_busy0(1'b1);
        for (int i = 0; i < 6; i++) push_word(8'(8'h61 + i));
        v0 = 1'b0;
        check("flush_count_pre", cnt0, 6);
        fl0 = 1'b1; v0 = 1'b1; d0 = 8'h77;
        step();
        fl0 = 1'b0; v0 = 1'b0;
        check("flush_count", cnt0, 0);
        check("flush_empty", emp0, 1);
        wait_busy0(1'b0);
        repeat (10) step();
        check("flush_pulses", en_pulses - base, 1);
        check("flush_rx_n", rx_q.size() - rb, 1);
        if (rx_q.size() > rb) check("flush_rx_data", rx_q[rb], 8'h3C);
        check("flush_idle", idle0, 1);

        // Busy never rises: sticky error after 4 busy-low cycles
        attached = 1'b0;
        v0 = 1'b1; d0 = 8'h11;
        step();
        v0 = 1'b0;
        step();
        check("to_launch", en0, 1);
        repeat (4) step();
        check("to_err_not_yet", err0, 0);
        step();
        check("to_err_set", err0, 1);
        check("to_idle", idle0, 1);
        v0 = 1'b1; d0 = 8'h22;
        step();
        v0 = 1'b0;
        step();
        check("to_next_launch", en0, 1);
        check("to_next_data", txd0, 8'h22);
        repeat (8) step();
        check("to_err_sticky", err0, 1);
        attached = 1'b1;

        // Reset mid-frame
        push_word(8'h5A);
        v0 = 1'b0;
        wait_busy0(1'b1);
        push_word(8'h5B);
        push_word(8'h5C);
        v0 = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1 check("midrst_ready", rdy0, 0);
        step();
        chk_reset0("midrst");
        rst = 1'b0;
        step();
        check("midrst_ready_after", rdy0, 1);
        check("midrst_no_launch", en0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
